mac_pipe: RTL and testbench

//  Pipelined multi-lane fixed-point multiply-accumulate, the successor to the single

---
 rtl/mac_pipe.sv | 158 +++++++++++++++
 tb/tb_mac_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe.sv
// mac_pipe: pipelined multi-lane signed fixed-point multiply-accumulate.
// Each accepted beat carries LANES pixel/weight pairs. The lane products are
// summed, accumulated over KERNEL_LEN beats, and the total is scaled back to
// DATA_WIDTH bits with FRAC_BIT fractional bits.
//
// Pipeline: P (lane products) -> S (lane sum) -> A (accumulate / output reg).
// All stages advance together on en = !out_valid | out_ready.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   acc_clr       synchronous flush of pipeline, accumulator and beat counter
//   in_valid      input beat valid
//   in_ready      input beat accepted when in_valid & in_ready
//   pixel, weight LANES packed signed operands, lane i = [i*DW +: DW]
//   out_valid     result valid, held until out_ready
//   out_ready     downstream accept
//   out           signed scaled result
//   out_sat       result was clamped (MULT_SAT_EN builds only, else 0)
//
// Configuration macro: MULT_SAT_EN -- saturate the scaled result to the
// signed DATA_WIDTH range instead of wrapping.
module mac_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BIT   = 8,
    parameter int LANES      = 4,
    parameter int KERNEL_LEN = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          acc_clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   pixel,
    input  logic [LANES*DATA_WIDTH-1:0]   weight,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out,
    output logic                          out_sat
);

    localparam int DW    = DATA_WIDTH;
    localparam int PW    = 2 * DW;
    localparam int ACC_W = 2 * DW + $clog2(LANES) + $clog2(KERNEL_LEN);
    localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_LEN - 1);

    logic                    w_en;
    logic                    w_accept;

    logic [CNT_W-1:0]        r_beat_cnt;
    logic                    r_p_valid;
    logic                    r_p_last;
    logic signed [PW-1:0]    r_prod [LANES];

    logic                    r_s_valid;
    logic                    r_s_last;
    logic signed [ACC_W-1:0] r_sum;
    logic signed [ACC_W-1:0] w_sum;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_total;
    logic [DW-1:0]           w_scaled;
    logic                    w_sat;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    // A beat presented alongside acc_clr is dropped even though in_ready = 1.
    assign w_accept = in_valid && w_en && !acc_clr;

    // Stage P: per-lane full-width products and beat position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_p_valid  <= 1'b0;
            r_p_last   <= 1'b0;
            for (int unsigned i = 0; i < LANES; i++) r_prod[i] <= '0;
        end else if (acc_clr) begin
            r_beat_cnt <= '0;
            r_p_valid  <= 1'b0;
        end else if (w_en) begin
            r_p_valid <= w_accept;
            if (w_accept) begin
                r_p_last   <= (r_beat_cnt == LAST_CNT);
                r_beat_cnt <= (r_beat_cnt == LAST_CNT) ? '0 : r_beat_cnt + 1'b1;
                for (int unsigned i = 0; i < LANES; i++)
                    r_prod[i] <= $signed(pixel[i*DW +: DW]) * $signed(weight[i*DW +: DW]);
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < LANES; i++)
            w_sum = w_sum + {{(ACC_W-PW){r_prod[i][PW-1]}}, r_prod[i]};
    end

    // Stage S: registered lane sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_valid <= 1'b0;
            r_s_last  <= 1'b0;
            r_sum     <= '0;
        end else if (acc_clr) begin
            r_s_valid <= 1'b0;
        end else if (w_en) begin
            r_s_valid <= r_p_valid;
            r_s_last  <= r_p_last;
            r_sum     <= w_sum;
        end
    end

    assign w_total = r_acc + r_sum;

`ifdef MULT_SAT_EN
    logic signed [ACC_W-1:0] w_shift;
    logic [ACC_W-DW:0]       w_top;

    // In range iff every bit above the result's sign bit matches it.
    always_comb begin
        w_shift  = w_total >>> FRAC_BIT;
        w_top    = w_shift[ACC_W-1:DW-1];
        w_sat    = 1'b0;
        w_scaled = w_shift[DW-1:0];
        if ((w_top != '0) && (w_top != '1)) begin
            w_sat    = 1'b1;
            w_scaled = w_shift[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign w_scaled = w_total[DW+FRAC_BIT-1:FRAC_BIT];
    assign w_sat    = 1'b0;
`endif

    // Stage A: accumulate; on the last beat emit the scaled total and restart.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_sat   <= 1'b0;
        end else if (acc_clr) begin
            r_acc     <= '0;
            out_valid <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_s_valid && r_s_last;
            if (r_s_valid) begin
                if (r_s_last) begin
                    r_acc   <= '0;
                    out     <= w_scaled;
                    out_sat <= w_sat;
                end else begin
                    r_acc <= w_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe with DW=16, FRAC=8, LANES=4, KERNEL_LEN=3,
// plus a randomised sum-of-products run with handshake gaps.
module tb_mac_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        acc_clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] pixel = '0;
    logic [63:0] weight = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out;
    logic        out_sat;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0] q[$];
    logic [16:0] exp_q[$];
    bit          rnd_done;

    mac_pipe #(.DATA_WIDTH(16), .FRAC_BIT(8), .LANES(4), .KERNEL_LEN(3)) dut (
        .clk(clk), .rst_n(rst_n), .acc_clr(acc_clr), .in_valid(in_valid),
        .in_ready(in_ready), .pixel(pixel), .weight(weight), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Results are taken on the edge following a negedge where valid & ready.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) q.push_back({out_sat, out});

    function automatic logic [63:0] rep4(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    function automatic logic [16:0] model(input longint total);
        longint sh;
        logic [63:0] shv;
        sh  = total >>> 8;
        shv = sh;
`ifdef MULT_SAT_EN
        if (sh > 32767)  return {1'b1, 16'h7FFF};
        if (sh < -32768) return {1'b1, 16'h8000};
`endif
        return {1'b0, shv[15:0]};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Present one beat and hold it until accepted (in_ready sampled mid-cycle).
    task automatic push(input logic [63:0] pv, input logic [63:0] wv);
        bit ok;
        int n;
        in_valid = 1'b1; pixel = pv; weight = wv;
        n = 0;
        forever begin
            @(negedge clk); #1;
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) break;
            n++;
            if (n > 300) begin
                vectors++; miscompares++;
                $display("FAIL push_timeout: in_ready stuck 0 (got %0b, need 1)", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic kernel(input logic [63:0] pv, input logic [63:0] wv);
        for (int b = 0; b < 3; b++) push(pv, wv);
    endtask

    task automatic wait_q(input int n);
        int c = 0;
        while (q.size() < n && c < 300) begin step(); c++; end
        if (q.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL result_timeout: results %0d, need %0d", q.size(), n);
        end
    endtask

    task automatic check_one(input string name, input logic [16:0] exp);
        logic [16:0] got;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no result, need out=%h sat=%0b", name, exp[15:0], exp[16]);
            return;
        end
        got = q.pop_front();
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: out=%h sat=%0b, need out=%h sat=%0b", name, got[15:0], got[16], exp[15:0], exp[16]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        vectors++;
        if ({out_valid, out, out_sat} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%0b out=%h sat=%0b, need 0 0000 0", out_valid, out, out_sat);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: %0b, need 1", in_ready);
        end
    endtask

    task automatic test_basic_latency();
        q.delete();
        out_ready = 1'b1;
        kernel(rep4(16'h0100), rep4(16'h0100));
        // Now 1 ns past the edge that took the last beat (t).
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL latency_t: out_valid=%0b, need 0", out_valid);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL latency_t1: out_valid=%0b, need 0", out_valid);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out !== 16'h0C00 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_t2: valid=%0b out=%h sat=%0b, need 1 0c00 0", out_valid, out, out_sat);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL latency_drop: out_valid=%0b, need 0", out_valid);
        end
        check_one("basic_12", {1'b0, 16'h0C00});
    endtask

    task automatic test_negative();
        q.delete();
        kernel(rep4(16'hFF00), rep4(16'h0200));
        wait_q(1);
        check_one("neg_24", {1'b0, 16'hE800});
    endtask

    task automatic test_overflow();
        q.delete();
        kernel(rep4(16'h7FFF), rep4(16'h7FFF));
        wait_q(1);
`ifdef MULT_SAT_EN
        check_one("overflow", {1'b1, 16'h7FFF});
`else
        check_one("overflow", {1'b0, 16'hF400});
`endif
    endtask

    task automatic test_back_to_back();
        int c;
        q.delete();
        out_ready = 1'b0;
        fork
            begin
                kernel(rep4(16'h0100), rep4(16'h0100));
                kernel(rep4(16'h0100), rep4(16'h0100));
            end
            begin
                c = 0;
                while (!out_valid && c < 100) begin step(); c++; end
                for (int i = 0; i < 5; i++) begin
                    vectors++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 16'h0C00) begin
                        miscompares++;
                        $display("FAIL stall_hold%0d: in_ready=%0b valid=%0b out=%h, need 0 1 0c00",
                                 i, in_ready, out_valid, out);
                    end
                    step();
                end
                out_ready = 1'b1;
            end
        join
        wait_q(2);
        repeat (10) step();
        vectors++;
        if (q.size() != 2) begin
            miscompares++; $display("FAIL b2b_count: results %0d, need 2", q.size());
        end
        check_one("b2b_first", {1'b0, 16'h0C00});
        check_one("b2b_second", {1'b0, 16'h0C00});
    endtask

    task automatic test_acc_clr();
        q.delete();
        push(rep4(16'h0100), rep4(16'h0100));
        push(rep4(16'h0100), rep4(16'h0100));
        acc_clr = 1'b1; in_valid = 1'b1;
        pixel = rep4(16'h0100); weight = rep4(16'h0100);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL clr_in_ready: %0b, need 1", in_ready);
        end
        step();
        acc_clr = 1'b0; in_valid = 1'b0;
        kernel({48'h0, 16'h0080}, {48'h0, 16'h0100});
        wait_q(1);
        repeat (8) step();
        vectors++;
        if (q.size() != 1) begin
            miscompares++; $display("FAIL clr_count: results %0d, need 1", q.size());
        end
        check_one("clr_1p5", {1'b0, 16'h0180});
    endtask

    task automatic test_async_reset();
        q.delete();
        push(rep4(16'h0100), rep4(16'h0100));
        push(rep4(16'h0100), rep4(16'h0100));
        rst_n = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || out !== 16'h0000 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%0b out=%h sat=%0b, need 0 0000 0", out_valid, out, out_sat);
        end
        step();
        rst_n = 1'b1;
        step();
        kernel(rep4(16'h0100), rep4(16'h0100));
        wait_q(1);
        repeat (6) step();
        vectors++;
        if (q.size() != 1) begin
            miscompares++; $display("FAIL rst_count: results %0d, need 1", q.size());
        end
        check_one("rst_resume", {1'b0, 16'h0C00});
    endtask

    task automatic test_random();
        q.delete(); exp_q.delete();
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    longint total = 0;
                    for (int b = 0; b < 3; b++) begin
                        logic [63:0] pv, wv;
                        logic [15:0] a, w;
                        for (int l = 0; l < 4; l++) begin
                            if (k % 2 == 0) begin
                                a = 16'($urandom_range(0, 1023)) - 16'd512;
                                w = 16'($urandom_range(0, 1023)) - 16'd512;
                            end else begin
                                a = 16'($urandom);
                                w = 16'($urandom);
                            end
                            pv[l*16 +: 16] = a;
                            wv[l*16 +: 16] = w;
                            total += longint'($signed(a)) * longint'($signed(w));
                        end
                        push(pv, wv);
                        repeat ($urandom_range(0, 2)) step();
                    end
                    exp_q.push_back(model(total));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_q(200);
        repeat (6) step();
        vectors++;
        if (q.size() != 200) begin
            miscompares++; $display("FAIL rnd_count: results %0d, need 200", q.size());
        end
        while (exp_q.size() > 0) check_one("random", exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_negative();
        test_overflow();
        test_back_to_back();
        test_acc_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
